// File: rtl/mult_rr_if.sv
// Request and response channels between client logic and mult_rr_scheduler.
// The client side is the master; the scheduler is the slave.
interface mult_rr_if #(
    parameter int NREQ = 4,
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_d;
    logic [NREQ*N-1:0] req_q;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [M+N-1:0]    resp_product;
    logic              resp_err;

    modport master (
        output req_valid, req_d, req_q, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, resp_err
    );

    modport slave (
        input  req_valid, req_d, req_q, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, resp_err
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one start/done multiplier core between NREQ
// requesters, with a watchdog that turns a silent core into an error response.
module mult_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int M       = 8,
    parameter int N       = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           rst,
    mult_rr_if.slave       bus,
    output logic           mul_start,
    output logic [M-1:0]   mul_d,
    output logic [N-1:0]   mul_q,
    input  logic           mul_done,
    input  logic [M+N-1:0] mul_product
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             mul_start_q, mul_start_d;
    logic [M-1:0]     mul_d_q, mul_d_d;
    logic [N-1:0]     mul_q_q, mul_q_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [M+N-1:0]   resp_product_q, resp_product_d;
    logic             resp_err_q, resp_err_d;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [M-1:0]     sel_d_s;
    logic [N-1:0]     sel_q_s;
    logic [NREQ-1:0]  req_ready_s;

    // Round-robin search: first valid at or above rr_ptr, then wrap to the lower indices.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_s && bus.req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
                grant_found_s = 1'b1;
                grant_id_s    = IDW'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_s && bus.req_valid[i]) begin
                grant_found_s = 1'b1;
                grant_id_s    = IDW'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_d_s = '0;
        sel_q_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_s == IDW'(i)) begin
                sel_d_s = bus.req_d[i*M +: M];
                sel_q_s = bus.req_q[i*N +: N];
            end else begin
                sel_d_s = sel_d_s;
            end
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        wd_d           = wd_q;
        mul_start_d    = 1'b0;
        mul_d_d        = mul_d_q;
        mul_q_d        = mul_q_q;
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_product_d = resp_product_q;
        resp_err_d     = resp_err_q;
        req_ready_s    = '0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is gated by rst so every output reads 0 while in reset.
                if (grant_found_s && !rst) begin
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready_s[i] = (grant_id_s == IDW'(i));
                    end
                    mul_d_d     = sel_d_s;
                    mul_q_d     = sel_q_s;
                    resp_id_d   = grant_id_s;
                    rr_ptr_d    = (grant_id_s == ID_LAST) ? '0 : grant_id_s + IDW'(1);
                    mul_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the final watchdog cycle still wins over the timeout.
                if (mul_done) begin
                    resp_product_d = mul_product;
                    resp_err_d     = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    resp_product_d = '0;
                    resp_err_d     = 1'b1;
                    resp_valid_d   = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            wd_q           <= '0;
            mul_start_q    <= 1'b0;
            mul_d_q        <= '0;
            mul_q_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            wd_q           <= wd_d;
            mul_start_q    <= mul_start_d;
            mul_d_q        <= mul_d_d;
            mul_q_q        <= mul_q_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_product_q <= resp_product_d;
            resp_err_q     <= resp_err_d;
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign bus.resp_err     = resp_err_q;
    assign mul_start        = mul_start_q;
    assign mul_d            = mul_d_q;
    assign mul_q            = mul_q_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: behavioural multiplier core plus a round-robin
// reference model driven by scenario tasks and randomized traffic.
module tb_mult_rr_scheduler;
    localparam int NREQ = 4;
    localparam int M = 8;
    localparam int N = 8;
    localparam int IDW = 2;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_rr_if #(.NREQ(NREQ), .M(M), .N(N), .IDW(IDW)) bus ();

    logic        mul_start;
    logic [7:0]  mul_d;
    logic [7:0]  mul_q;
    logic        mul_done;
    logic [15:0] mul_product;

    mult_rr_scheduler #(.NREQ(NREQ), .M(M), .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mul_start(mul_start), .mul_d(mul_d), .mul_q(mul_q),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    // Behavioural core: done exactly core_lat cycles after the start pulse.
    int          core_lat = 18;
    bit          core_en = 1'b1;
    bit          stale_done = 1'b0;
    bit          core_busy = 1'b0;
    int          core_cnt = 0;
    logic [15:0] core_prod = 16'h0;
    int          start_count = 0;

    always @(posedge clk) begin
        if (mul_start) begin
            core_busy   <= 1'b1;
            core_cnt    <= 1;
            core_prod   <= 16'(mul_d) * 16'(mul_q);
            start_count <= start_count + 1;
        end else if (core_busy) begin
            if (mul_done) core_busy <= 1'b0;
            else core_cnt <= core_cnt + 1;
        end
    end

    assign mul_done    = stale_done | (core_en & core_busy & (core_cnt == core_lat));
    assign mul_product = stale_done ? 16'hBEEF : core_prod;

    int n_checks = 0;
    int n_pass = 0;
    int rr_model = 0;

    function automatic int pick(input logic [3:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(rr_model + k) % NREQ]) return (rr_model + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_ready(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != 4'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_resp(output bit ok, output int cyc, output bit saw_rdy);
        ok = 1'b0;
        cyc = 0;
        saw_rdy = 1'b0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != 4'b0) saw_rdy = 1'b1;
            if (bus.resp_valid) ok = 1'b1;
        end
    endtask

    task automatic release_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr_model = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_d = 32'hA5A5A5A5;
        bus.req_q = 32'h5A5A5A5A;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b exp 0", bus.req_ready); else n_pass++;
        n_checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b exp 0", mul_start); else n_pass++;
        n_checks++; if ({mul_d, mul_q} !== 16'h0) $display("FAIL reset_operands: got %h exp 0", {mul_d, mul_q}); else n_pass++;
        n_checks++; if ({bus.resp_valid, bus.resp_err, bus.resp_id} !== 4'b0) $display("FAIL reset_resp_flags: got %b exp 0", {bus.resp_valid, bus.resp_err, bus.resp_id}); else n_pass++;
        n_checks++; if (bus.resp_product !== 16'h0) $display("FAIL reset_resp_product: got %h exp 0", bus.resp_product); else n_pass++;
        bus.req_valid = 4'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rr_model = 0;
    endtask

    task automatic test_single();
        bit ok; int cyc; bit saw; int s0; int g;
        core_lat = 18;
        bus.req_d[7:0] = 8'hFF;
        bus.req_q[7:0] = 8'hFF;
        bus.req_valid = 4'b0001;
        wait_ready(ok, cyc);
        g = pick(4'b0001);
        n_checks++; if (!ok || bus.req_ready !== (4'b0001 << g)) $display("FAIL single_grant: got %b exp %b", bus.req_ready, 4'b0001 << g); else n_pass++;
        s0 = start_count;
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        @(negedge clk);
        n_checks++; if (mul_start !== 1'b1) $display("FAIL single_start: got %b exp 1", mul_start); else n_pass++;
        n_checks++; if ({mul_d, mul_q} !== 16'hFFFF) $display("FAIL single_operands: got %h exp ffff", {mul_d, mul_q}); else n_pass++;
        wait_resp(ok, cyc, saw);
        n_checks++; if (!ok || cyc != 19) $display("FAIL single_latency: got %0d exp 19", cyc); else n_pass++;
        n_checks++; if (bus.resp_id !== 2'd0 || bus.resp_err !== 1'b0) $display("FAIL single_id_err: got %0d/%b exp 0/0", bus.resp_id, bus.resp_err); else n_pass++;
        n_checks++; if (bus.resp_product !== 16'hFE01) $display("FAIL single_product: got %h exp fe01", bus.resp_product); else n_pass++;
        n_checks++; if (start_count - s0 != 1) $display("FAIL single_start_count: got %0d exp 1", start_count - s0); else n_pass++;
        release_resp();
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL single_resp_drop: got %b exp 0", bus.resp_valid); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_all_four();
        bit ok; int cyc; bit saw; int g;
        logic [3:0] pend;
        int grants [4];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_d[i*8 +: 8] = 8'((i + 1) * 3);
            bus.req_q[i*8 +: 8] = 8'd5;
            grants[i] = 0;
        end
        core_lat = 6;
        pend = 4'hF;
        bus.req_valid = pend;
        for (int j = 0; j < NREQ; j++) begin
            wait_ready(ok, cyc);
            g = pick(pend);
            n_checks++; if (!ok || bus.req_ready !== (4'b0001 << g)) $display("FAIL all4_grant%0d: got %b exp %b", j, bus.req_ready, 4'b0001 << g); else n_pass++;
            if (j > 0) begin
                n_checks++; if (cyc != 1) $display("FAIL all4_regrant_delay%0d: got %0d exp 1", j, cyc); else n_pass++;
            end
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grants[i]++;
            @(posedge clk); #1;
            pend[g] = 1'b0;
            bus.req_valid = pend;
            rr_model = (g + 1) % NREQ;
            wait_resp(ok, cyc, saw);
            n_checks++; if (!ok || bus.resp_id !== 2'(g)) $display("FAIL all4_id%0d: got %0d exp %0d", j, bus.resp_id, g); else n_pass++;
            n_checks++; if (bus.resp_product !== 16'(15 * (g + 1))) $display("FAIL all4_product%0d: got %0d exp %0d", j, bus.resp_product, 15 * (g + 1)); else n_pass++;
            n_checks++; if (saw) $display("FAIL all4_ready_busy%0d: got 1 exp 0", j); else n_pass++;
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            n_checks++; if (grants[i] != 1) $display("FAIL all4_ready_count%0d: got %0d exp 1", i, grants[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; bit saw; int g; bit moved; bit rdy;
        logic [15:0] prod0; logic [1:0] id0;
        bus.req_d[7:0] = 8'h21; bus.req_q[7:0] = 8'h03;
        bus.req_d[15:8] = 8'h10; bus.req_q[15:8] = 8'h11;
        core_lat = 4;
        bus.req_valid = 4'b0001;
        wait_ready(ok, cyc);
        g = pick(4'b0001);
        @(posedge clk); #1;
        rr_model = (g + 1) % NREQ;
        bus.req_valid = 4'b0010;
        wait_resp(ok, cyc, saw);
        prod0 = bus.resp_product;
        id0 = bus.resp_id;
        n_checks++; if (!ok || prod0 !== 16'h0063 || id0 !== 2'd0) $display("FAIL bp_first: got %h/%0d exp 0063/0", prod0, id0); else n_pass++;
        moved = 1'b0; rdy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_product !== prod0 || bus.resp_id !== id0 || bus.resp_err !== 1'b0) moved = 1'b1;
            if (bus.req_ready !== 4'b0) rdy = 1'b1;
        end
        n_checks++; if (moved) $display("FAIL bp_resp_stable: got 1 exp 0"); else n_pass++;
        n_checks++; if (rdy) $display("FAIL bp_no_ready: got 1 exp 0"); else n_pass++;
        release_resp();
        @(negedge clk);
        g = pick(4'b0010);
        n_checks++; if (bus.req_ready !== (4'b0001 << g)) $display("FAIL bp_next_grant: got %b exp %b", bus.req_ready, 4'b0001 << g); else n_pass++;
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        wait_resp(ok, cyc, saw);
        n_checks++; if (!ok || bus.resp_product !== 16'h0110 || bus.resp_id !== 2'd1) $display("FAIL bp_second: got %h/%0d exp 0110/1", bus.resp_product, bus.resp_id); else n_pass++;
        release_resp();
    endtask

    task automatic test_watchdog();
        bit ok; int cyc; bit saw; int g;
        core_en = 1'b0;
        bus.req_d[23:16] = 8'h1F; bus.req_q[23:16] = 8'h1F;
        bus.req_valid = 4'b0100;
        wait_ready(ok, cyc);
        g = pick(4'b0100);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        @(negedge clk);
        wait_resp(ok, cyc, saw);
        n_checks++; if (!ok || cyc != TIMEOUT + 1) $display("FAIL wd_latency: got %0d exp %0d", cyc, TIMEOUT + 1); else n_pass++;
        n_checks++; if (bus.resp_err !== 1'b1 || bus.resp_product !== 16'h0) $display("FAIL wd_err: got %b/%h exp 1/0000", bus.resp_err, bus.resp_product); else n_pass++;
        n_checks++; if (bus.resp_id !== 2'(g) || mul_d !== 8'h1F) $display("FAIL wd_id_hold: got %0d/%h exp %0d/1f", bus.resp_id, mul_d, g); else n_pass++;
        release_resp();
        core_en = 1'b1;
        core_lat = 3;
        bus.req_d[31:24] = 8'h01; bus.req_q[31:24] = 8'h01;
        bus.req_valid = 4'b1000;
        wait_ready(ok, cyc);
        g = pick(4'b1000);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        wait_resp(ok, cyc, saw);
        n_checks++; if (!ok || bus.resp_err !== 1'b0 || bus.resp_product !== 16'h0001) $display("FAIL wd_recover: got %b/%h exp 0/0001", bus.resp_err, bus.resp_product); else n_pass++;
        release_resp();
    endtask

    task automatic test_mid_reset();
        bit ok; int cyc; bit saw; bit bad; int g;
        core_en = 1'b0;
        bus.req_d[15:8] = 8'h12; bus.req_q[15:8] = 8'h34;
        bus.req_valid = 4'b0010;
        wait_ready(ok, cyc);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr_model = 0;
        @(negedge clk);
        n_checks++; if ({mul_start, mul_d, mul_q} !== 17'h0) $display("FAIL mrst_core_outs: got %h exp 0", {mul_start, mul_d, mul_q}); else n_pass++;
        n_checks++; if ({bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_product} !== 20'h0) $display("FAIL mrst_resp_outs: got %h exp 0", {bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_product}); else n_pass++;
        @(posedge clk); #1;
        stale_done = 1'b1;
        @(posedge clk); #1;
        stale_done = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || mul_start !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL mrst_stale_done: got 1 exp 0"); else n_pass++;
        @(posedge clk); #1;
        core_en = 1'b1;
        core_lat = 9;
        bus.req_d[7:0] = 8'h1F; bus.req_q[7:0] = 8'h1F;
        bus.req_valid = 4'b0001;
        wait_ready(ok, cyc);
        g = pick(4'b0001);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        wait_resp(ok, cyc, saw);
        n_checks++; if (!ok || bus.resp_product !== 16'h03C1 || bus.resp_id !== 2'd0) $display("FAIL mrst_after: got %h/%0d exp 03c1/0", bus.resp_product, bus.resp_id); else n_pass++;
        release_resp();
    endtask

    task automatic test_rr_wrap();
        bit ok; int cyc; bit saw; int g;
        logic [3:0] pend;
        core_lat = 2;
        bus.req_d[23:16] = 8'd7; bus.req_q[23:16] = 8'd9;
        bus.req_valid = 4'b0100;
        wait_ready(ok, cyc);
        g = pick(4'b0100);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rr_model = (g + 1) % NREQ;
        wait_resp(ok, cyc, saw);
        release_resp();
        bus.req_d[7:0] = 8'd11; bus.req_q[7:0] = 8'd13;
        pend = 4'b0101;
        bus.req_valid = pend;
        for (int j = 0; j < 2; j++) begin
            wait_ready(ok, cyc);
            g = pick(pend);
            n_checks++; if (!ok || bus.req_ready !== (4'b0001 << g)) $display("FAIL wrap_grant%0d: got %b exp %b", j, bus.req_ready, 4'b0001 << g); else n_pass++;
            @(posedge clk); #1;
            pend[g] = 1'b0;
            bus.req_valid = pend;
            rr_model = (g + 1) % NREQ;
            wait_resp(ok, cyc, saw);
            n_checks++; if (!ok || bus.resp_id !== 2'(g)) $display("FAIL wrap_id%0d: got %0d exp %0d", j, bus.resp_id, g); else n_pass++;
            release_resp();
        end
    endtask

    task automatic test_random();
        bit ok; int cyc; bit saw; int g; int dly;
        logic [3:0] pend;
        logic [7:0] d [4];
        logic [7:0] q [4];
        for (int r = 0; r < 25; r++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                d[i] = 8'($urandom);
                q[i] = 8'($urandom);
                bus.req_d[i*8 +: 8] = d[i];
                bus.req_q[i*8 +: 8] = q[i];
            end
            core_lat = $urandom_range(1, 20);
            bus.req_valid = pend;
            while (pend != 4'b0) begin
                wait_ready(ok, cyc);
                g = pick(pend);
                n_checks++; if (!ok || bus.req_ready !== (4'b0001 << g)) $display("FAIL rnd_grant r%0d: got %b exp %b", r, bus.req_ready, 4'b0001 << g); else n_pass++;
                if (!ok) return;
                @(posedge clk); #1;
                pend[g] = 1'b0;
                bus.req_valid = pend;
                rr_model = (g + 1) % NREQ;
                wait_resp(ok, cyc, saw);
                n_checks++; if (!ok || bus.resp_id !== 2'(g) || bus.resp_err !== 1'b0) $display("FAIL rnd_id r%0d: got %0d/%b exp %0d/0", r, bus.resp_id, bus.resp_err, g); else n_pass++;
                n_checks++; if (bus.resp_product !== 16'(d[g]) * 16'(q[g])) $display("FAIL rnd_product r%0d: got %h exp %h", r, bus.resp_product, 16'(d[g]) * 16'(q[g])); else n_pass++;
                n_checks++; if (saw || cyc != core_lat + 2) $display("FAIL rnd_timing r%0d: got %0d/%b exp %0d/0", r, cyc, saw, core_lat + 2); else n_pass++;
                if (!ok) return;
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                release_resp();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 4'b0;
        bus.req_d = 32'h0;
        bus.req_q = 32'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_watchdog();
        test_mid_reset();
        test_rr_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one sequential shift-add multiplier core between NREQ requesters. Uses round-robin arbitration and a start/done handshake to the core. Returns each product with the winning requester's ID over a valid/ready response channel. A watchdog flags a core that fails to assert done. Sits between client logic and the multiplier datapath; holds operands stable for the whole core operation.

Parameters:
NREQ, 4, number of requesters (2..8)
M, 8, multiplicand width
N, 8, multiplier width
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
TIMEOUT, 40, max cycles from mul_start to mul_done before an error response

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_d  in  NREQ*M  multiplicands; requester i at [i*M +: M]
req_q  in  NREQ*N  multipliers; requester i at [i*N +: N]
mul_start  out  1  one-cycle pulse that launches the core
mul_d  out  M  registered operand to the core
mul_q  out  N  registered operand to the core
mul_done  in  1  core completion pulse
mul_product  in  M+N  core result; valid while mul_done=1
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  IDW  index of the requester served
resp_product  out  M+N  product; zero on error
resp_err  out  1  watchdog timeout flag

Behaviour:
- Reset values: state=IDLE, rr_ptr=0; every output 0, including req_ready, mul_start, mul_d, mul_q and all resp_* outputs; watchdog count=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid=1:
  - Grant the first i with req_valid[i]=1, searching upward from rr_ptr with wrap-around.
  - Assert req_ready[i] combinationally in this cycle only.
  - On that edge: latch req_d[i] into mul_d, req_q[i] into mul_q, and i into resp_id; set rr_ptr=(i+1) mod NREQ; go to ISSUE.
- IDLE, when no req_valid: stay in IDLE; req_ready=0.
- Requester handshake: a requester's transfer occurs on the cycle where req_valid[i]=1 and req_ready[i]=1. req_ready never asserts outside IDLE.
- ISSUE: mul_start=1 for exactly one cycle; clear watchdog; go to WAIT.
- mul_d and mul_q hold their values from grant until the scheduler next returns to IDLE.
- WAIT: watchdog increments each cycle.
  - If mul_done=1: latch mul_product into resp_product; resp_err=0; go to RESP.
  - Else if watchdog reaches TIMEOUT-1: resp_product=0; resp_err=1; go to RESP.
  - If mul_done and timeout occur in the same cycle, done wins.
- mul_done is ignored outside WAIT.
- RESP: resp_valid=1. resp_id, resp_product and resp_err stay stable until resp_ready=1. On the edge with resp_valid and resp_ready both 1, go to IDLE and drop resp_valid.
- Back-pressure: no new grant is issued while a response is pending.
- Latency, with the core taking L cycles from start to done and resp_ready held at 1:
  - grant edge -> mul_start pulse: 1 cycle;
  - mul_start -> resp_valid: L+1 cycles;
  - resp handshake -> next possible grant: 1 cycle.
- Fairness: with all requesters valid continuously, grants cycle 0,1,2,3,0,... No requester waits more than NREQ-1 other services.
- Width rule: the product is M+N bits and is passed through unmodified. The scheduler performs no arithmetic.
- rst=1 in any state returns to IDLE with reset values on the next edge. A core operation in flight is abandoned. A mul_done arriving after reset is ignored.

Test Plan:
- Single request: req0 with D=0xFF, Q=0xFF; behavioural core with L=18 -> one mul_start pulse, then resp_valid with resp_id=0, resp_product=0xFE01, resp_err=0.
- All four requesters valid at once, operands (i+1)*3 and 5:
  - grant order 0,1,2,3;
  - products 15, 30, 45, 60 with matching resp_id;
  - req_ready one-hot, with exactly one assertion per requester.
- Back-pressure: hold resp_ready=0 for 10 cycles with req1 pending -> resp fields stable, req_ready[1] stays 0. Release -> req1 granted the cycle after the handshake.
- Watchdog: core never asserts done, D=0x1F, Q=0x1F -> after 40 WAIT cycles, resp_err=1, resp_product=0. The next request (1*1) completes normally with 0x0001.
- Mid-operation reset: assert rst in WAIT, then the core's stale done 3 cycles later -> all outputs 0 and no resp_valid. The following request 0x1F*0x1F returns 0x03C1.
- Round-robin wrap: rr_ptr=3 with req0 and req2 valid -> req0 granted first, then req2.
